// File: rtl/kcode_bus_arbiter.sv
// Two-port (instruction/data) arbiter onto a single kernel-code RAM port, IDLE/ACCESS/GAP FSM.
// Define KCA_TIMEOUT_EN to abort an access with err after TIMEOUT_CYCLES ACCESS cycles without ready.
module kcode_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [3:0]  dm_byte_sel_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        err_o,
    output logic        ce_o,
    output logic        we_in_o,
    output logic [31:0] addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  byte_sel_o,
    input  logic [31:0] rd_data_i,
    input  logic        ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_GAP
    } state_e;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    state_e      state_q, state_d;
    logic        ce_q, ce_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  bsel_q, bsel_d;
    logic        gnt_dm_q, gnt_dm_d;
    logic        if_ack_q, if_ack_d;
    logic        dm_ack_q, dm_ack_d;
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        pick_dm;

`ifdef KCA_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        ce_d       = ce_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bsel_d     = bsel_q;
        gnt_dm_d   = gnt_dm_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        pick_dm    = 1'b0;
`ifdef KCA_TIMEOUT_EN
        tmo_d      = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                ce_d = 1'b0;
                if (if_req_i || dm_req_i) begin
                    // gnt_dm_q doubles as the last-grant flag; a tie goes to the other port
                    pick_dm  = dm_req_i && (!if_req_i || !gnt_dm_q);
                    gnt_dm_d = pick_dm;
                    ce_d     = 1'b1;
                    state_d  = ST_ACCESS;
                    if (pick_dm) begin
                        we_d    = dm_we_i;
                        addr_d  = dm_addr_i;
                        wdata_d = dm_wdata_i;
                        bsel_d  = dm_byte_sel_i;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr_i;
                        wdata_d = '0;
                        bsel_d  = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (ready_i) begin
                    if (gnt_dm_q) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = rd_data_i;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = rd_data_i;
                    end
                    ce_d    = 1'b0;
                    state_d = ST_GAP;
                end
`ifdef KCA_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    if (gnt_dm_q) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                    err_d   = 1'b1;
                    ce_d    = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                ce_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                ce_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ce_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bsel_q     <= '0;
            gnt_dm_q   <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef KCA_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ce_q       <= ce_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bsel_q     <= bsel_d;
            gnt_dm_q   <= gnt_dm_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef KCA_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign ce_o       = ce_q;
    assign we_in_o    = we_q;
    assign addr_o     = addr_q;
    assign wr_data_o  = wdata_q;
    assign byte_sel_o = bsel_q;
    assign if_ack_o   = if_ack_q;
    assign dm_ack_o   = dm_ack_q;
    assign err_o      = err_q;
    assign if_rdata_o = if_rdata_q;
    assign dm_rdata_o = dm_rdata_q;

endmodule

// File: doc/kcode_bus_arbiter.md
KCODE_BUS_ARBITER -- requirements
Module: kcode_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of ACCESS cycles without ready before abort (used only with KCA_TIMEOUT_EN).
REQ-002 SHALL have one clock and a synchronous active-high reset: clk input 1, the single clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 if_req  input  1  instruction fetch request, level, held until if_ack.
REQ-005 if_addr  input  32  instruction byte address.
REQ-006 if_rdata  output  32  fetched word, valid while if_ack=1.
REQ-007 if_ack  output  1  one-cycle completion pulse, instruction port.
REQ-008 dm_req  input  1  data request, level, held until dm_ack.
REQ-009 dm_we  input  1  1=write, 0=read.
REQ-010 dm_addr  input  32  data byte address.
REQ-011 dm_wdata  input  32  write data.
REQ-012 dm_byte_sel  input  4  byte enables for writes.
REQ-013 dm_rdata  output  32  read word, valid while dm_ack=1.
REQ-014 dm_ack  output  1  one-cycle completion pulse, data port.
REQ-015 err  output  1  high with an ack when that access timed out.
REQ-016 ce, we_in, addr[32], wr_data[32], byte_sel[4]  output  drive the downstream kernel-code RAM port.
REQ-017 rd_data  input  32  and ready  input  1  from the RAM port.

Function
REQ-018 FSM states IDLE, ACCESS, GAP; all RAM-side outputs registered.
REQ-019 IDLE: any req pending -> latch the winner's we/addr/wdata/byte_sel, assert ce next cycle, go ACCESS; none -> stay, ce=0.
REQ-020 Arbitration: only one pending wins; both pending -> the port not granted last wins; last-grant flag resets to instruction, so data wins the first tie.
REQ-021 Instruction grants drive we_in=0, byte_sel=4'b0000, wr_data=0.
REQ-022 ACCESS: ce and latched outputs held constant every cycle until ready=1.
REQ-023 ready=1 in ACCESS: register rd_data into granted port's rdata, pulse that port's ack next cycle, drop ce next cycle, go GAP.
REQ-024 GAP: ce=0 exactly one cycle (a fresh ce rising edge is required for ready), then IDLE; requests are not sampled in GAP.
REQ-025 Latency: req sampled in IDLE at cycle N -> ce=1 at N+1 -> ready at N+3 -> ack at N+4; back-to-back grant earliest at N+5 (IDLE), ce at N+6.
REQ-026 ack never asserted on both ports in the same cycle; rdata holds its last value when ack=0.
REQ-027 Write accesses complete identically; dm_rdata on a write ack is don't-care.
REQ-028 ready while not in ACCESS is ignored.

Reset
REQ-029 On rst: state IDLE, ce=0, we_in=0, addr=0, wr_data=0, byte_sel=0, if_ack=0, dm_ack=0, err=0, if_rdata=0, dm_rdata=0, last-grant=instruction, timeout counter=0.
REQ-030 rst during ACCESS abandons the transfer with no ack; ce low on the cycle after rst is sampled.

Configuration
REQ-031 Macro KCA_TIMEOUT_EN defined: counter counts ACCESS cycles; reaching TIMEOUT_CYCLES without ready -> ack with err=1, rdata=0, ce dropped, go GAP; counter clears on leaving ACCESS.
REQ-032 Macro KCA_TIMEOUT_EN undefined: no counter, ACCESS waits for ready indefinitely, err tied 0.

Verification
REQ-033 Read: dm_req=1, dm_we=0, dm_addr=0x0000_0010, RAM returns 0xDEAD_BEEF -> ce high cycles 1-3, dm_ack=1 at cycle 4 with dm_rdata=0xDEAD_BEEF, err=0.
REQ-034 Write: dm_we=1, dm_addr=0x20, dm_wdata=0x1234_5678, dm_byte_sel=4'b0011 -> we_in=1, byte_sel=0011 held while ce=1; dm_ack at cycle 4.
REQ-035 Tie: if_req and dm_req asserted together and held -> data served first, instruction second, alternating thereafter; ce low for exactly one cycle between accesses.
REQ-036 Reset mid-access: rst at cycle 2 of ACCESS -> ce=0 and all acks 0 next cycle; subsequent if_req completes normally.
REQ-037 With KCA_TIMEOUT_EN, TIMEOUT_CYCLES=16, ready held 0 -> after 16 ACCESS cycles if_ack=1, err=1, if_rdata=0; without macro ce stays high through 100 cycles, no ack.
